// File: rtl/collider_array.sv
// rtl/collider_array.sv - per-entity terrain collision scanner over streamed column bitmaps
// Optional ground-distance measurement is built only when COLLIDER_GROUND_DIST_EN is defined.
module collider_array #(
  parameter int NUM_ENT = 4,
  parameter int COL_H   = 512,
  parameter int CW      = 10
`ifdef COLLIDER_GROUND_DIST_EN
  , parameter int MAX_DIST = 63
`endif
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    frame_start,
  input  logic                    col_valid,
  input  logic                    col_last,
  input  logic [CW-1:0]           DrawX,
  input  logic [COL_H-1:0]        terrain_data,
  input  logic [NUM_ENT*CW-1:0]   ent_X,
  input  logic [NUM_ENT*CW-1:0]   ent_Y,
  input  logic [NUM_ENT*CW-1:0]   ent_D,
  input  logic [NUM_ENT*CW-1:0]   ent_U,
  input  logic [NUM_ENT*CW-1:0]   ent_L,
  input  logic [NUM_ENT*CW-1:0]   ent_R,
  output logic [NUM_ENT-1:0]      DD,
  output logic [NUM_ENT-1:0]      UU,
  output logic [NUM_ENT-1:0]      LL,
  output logic [NUM_ENT-1:0]      RR,
  output logic                    coll_valid,
  output logic                    busy
`ifdef COLLIDER_GROUND_DIST_EN
  , output logic [NUM_ENT*8-1:0]  ground_dist
`endif
);

  localparam int RW = $clog2(COL_H);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t state_q, state_d;
  logic [NUM_ENT*CW-1:0] x_q, x_d, y_q, y_d, dn_q, dn_d, up_q, up_d, lf_q, lf_d, rt_q, rt_d;
  logic [NUM_ENT-1:0] acc_dd_q, acc_dd_d, acc_uu_q, acc_uu_d, acc_ll_q, acc_ll_d, acc_rr_q, acc_rr_d;
  logic [NUM_ENT-1:0] dd_q, dd_d, uu_q, uu_d, ll_q, ll_d, rr_q, rr_d;
`ifdef COLLIDER_GROUND_DIST_EN
  logic [NUM_ENT*8-1:0] acc_gd_q, acc_gd_d, gd_q, gd_d;
`endif
  logic accept, load_out;

  function automatic logic row_in(input logic signed [CW+1:0] row);
    return !row[CW+1] && (row[CW:0] < (CW+1)'(COL_H));
  endfunction

  // Out-of-range rows read as empty; the index is always legal so no X leaks.
  function automatic logic row_bit(input logic [COL_H-1:0] data, input logic signed [CW+1:0] row);
    return row_in(row) && data[row[RW-1:0]];
  endfunction

  always_comb begin : next_state
    logic signed [CW:0]   e_l, e_r, e_t, e_b;
    logic signed [CW+1:0] dx, lft, rgt, top, bot, rr;
    logic                 span, hit_cols;
`ifdef COLLIDER_GROUND_DIST_EN
    logic signed [CW+1:0] gstart;
    logic [7:0]           cnt;
    logic                 run;
    gstart   = '0;
    cnt      = '0;
    run      = 1'b0;
    acc_gd_d = acc_gd_q;
    gd_d     = gd_q;
`endif
    e_l = '0; e_r = '0; e_t = '0; e_b = '0;
    lft = '0; rgt = '0; top = '0; bot = '0; rr = '0;
    span = 1'b0; hit_cols = 1'b0;
    state_d  = state_q;
    x_d = x_q; y_d = y_q; dn_d = dn_q; up_d = up_q; lf_d = lf_q; rt_d = rt_q;
    acc_dd_d = acc_dd_q; acc_uu_d = acc_uu_q; acc_ll_d = acc_ll_q; acc_rr_d = acc_rr_q;
    dd_d = dd_q; uu_d = uu_q; ll_d = ll_q; rr_d = rr_q;

    accept   = (state_q == SCAN) && col_valid && !frame_start;
    load_out = (state_q == DONE) && !frame_start && !reset;
    dx       = $signed({2'b00, DrawX});

    case (state_q)
      SCAN:    if (accept && col_last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = state_q;
    endcase

    if (load_out) begin
      dd_d = acc_dd_q; uu_d = acc_uu_q; ll_d = acc_ll_q; rr_d = acc_rr_q;
`ifdef COLLIDER_GROUND_DIST_EN
      gd_d = acc_gd_q;
`endif
    end

    for (int i = 0; i < NUM_ENT; i++) begin
      // Edges wrap at CW+1 signed bits; widened afterwards only for comparison.
      e_l = $signed({1'b0, x_q[i*CW +: CW]}) - $signed({1'b0, lf_q[i*CW +: CW]});
      e_r = $signed({1'b0, x_q[i*CW +: CW]}) + $signed({1'b0, rt_q[i*CW +: CW]});
      e_t = $signed({1'b0, y_q[i*CW +: CW]}) - $signed({1'b0, up_q[i*CW +: CW]});
      e_b = $signed({1'b0, y_q[i*CW +: CW]}) + $signed({1'b0, dn_q[i*CW +: CW]});
      lft = {e_l[CW], e_l};
      rgt = {e_r[CW], e_r};
      top = {e_t[CW], e_t};
      bot = {e_b[CW], e_b};
      hit_cols = (dx >= lft) && (dx <= rgt);

      span = 1'b0;
      for (int r = 0; r < COL_H; r++) begin
        rr = (CW+2)'(r);
        if ((rr >= top) && (rr <= bot)) span = span | terrain_data[rr[RW-1:0]];
      end

      if (accept) begin
        if (hit_cols) begin
          acc_dd_d[i] = acc_dd_q[i] | row_bit(terrain_data, bot);
          acc_uu_d[i] = acc_uu_q[i] | row_bit(terrain_data, top);
        end
        if (dx == lft) acc_ll_d[i] = acc_ll_q[i] | span;
        if (dx == rgt) acc_rr_d[i] = acc_rr_q[i] | span;
      end

`ifdef COLLIDER_GROUND_DIST_EN
      // Clear run below the feet; rows past the bitmap count as solid ground.
      gstart = bot + (CW+2)'(1);
      cnt    = '0;
      run    = 1'b1;
      for (int k = 0; k < MAX_DIST; k++) begin
        rr = gstart + (CW+2)'(k);
        if (run && row_in(rr) && !terrain_data[rr[RW-1:0]]) cnt = cnt + 8'd1;
        else run = 1'b0;
      end
      if (accept && (DrawX == x_q[i*CW +: CW])) acc_gd_d[i*8 +: 8] = cnt;
`endif
    end

    if (frame_start) begin
      x_d = ent_X; y_d = ent_Y; dn_d = ent_D; up_d = ent_U; lf_d = ent_L; rt_d = ent_R;
      acc_dd_d = '0; acc_uu_d = '0; acc_ll_d = '0; acc_rr_d = '0;
`ifdef COLLIDER_GROUND_DIST_EN
      acc_gd_d = '0;
`endif
      state_d = SCAN;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      x_q <= '0; y_q <= '0; dn_q <= '0; up_q <= '0; lf_q <= '0; rt_q <= '0;
      acc_dd_q <= '0; acc_uu_q <= '0; acc_ll_q <= '0; acc_rr_q <= '0;
      dd_q <= '0; uu_q <= '0; ll_q <= '0; rr_q <= '0;
`ifdef COLLIDER_GROUND_DIST_EN
      acc_gd_q <= '0; gd_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      x_q <= x_d; y_q <= y_d; dn_q <= dn_d; up_q <= up_d; lf_q <= lf_d; rt_q <= rt_d;
      acc_dd_q <= acc_dd_d; acc_uu_q <= acc_uu_d; acc_ll_q <= acc_ll_d; acc_rr_q <= acc_rr_d;
      dd_q <= dd_d; uu_q <= uu_d; ll_q <= ll_d; rr_q <= rr_d;
`ifdef COLLIDER_GROUND_DIST_EN
      acc_gd_q <= acc_gd_d; gd_q <= gd_d;
`endif
    end
  end

  assign DD         = dd_d;
  assign UU         = uu_d;
  assign LL         = ll_d;
  assign RR         = rr_d;
  assign coll_valid = load_out;
  assign busy       = (state_q == SCAN);
`ifdef COLLIDER_GROUND_DIST_EN
  assign ground_dist = gd_d;
`endif

endmodule
